// File: rtl/ram_port2_requester_pkg.sv
// Shared definitions for the port-2 RAM requester: FSM encoding and command layout.
package ram_port2_requester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    localparam int STALL_CNT_W = 16;

    // A command is packed as {we, address, data}.
    function automatic int cmd_width(input int address_width, input int data_width);
        return 1 + address_width + data_width;
    endfunction

endpackage

// File: rtl/ram_port2_requester_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; depth is 2**FIFO_AW.
module ram_port2_requester_cmd_fifo #(
    parameter int WIDTH   = 25,
    parameter int FIFO_AW = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [WIDTH-1:0]   i_data,
    output logic [WIDTH-1:0]   o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_count
);

    localparam int DEPTH = 2**FIFO_AW;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (FIFO_AW+1)'(DEPTH));
    assign o_empty = (r_count == (FIFO_AW+1)'(0));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= FIFO_AW'(0);
            r_rd_ptr <= FIFO_AW'(0);
            r_count  <= (FIFO_AW+1)'(0);
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ram_port2_requester.sv
// Low-priority requester driving port 2 of the priority RAM arbiter from a command FIFO.
// Define RAM_PORT2_STATS_EN to add the 16-bit saturating stall_count_output.
module ram_port2_requester
    import ram_port2_requester_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int FIFO_AW       = 2
) (
    input  logic                     clk_input,
    input  logic                     rst_n_input,
    input  logic                     cmd_valid_input,
    output logic                     cmd_ready_output,
    input  logic                     cmd_we_input,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address_input,
    input  logic [DATA_WIDTH-1:0]    cmd_data_input,
    output logic                     rd_valid_output,
    output logic [DATA_WIDTH-1:0]    rd_data_output,
    output logic                     busy_output,
    input  logic                     is_RAM_available_input,
    output logic                     WE2_output,
    output logic                     CE2_output,
    output logic [ADDRESS_WIDTH-1:0] address2_output,
    inout  wire  [DATA_WIDTH-1:0]    data2_inout
`ifdef RAM_PORT2_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]   stall_count_output
`endif
);

    localparam int CMD_WIDTH = cmd_width(ADDRESS_WIDTH, DATA_WIDTH);

    logic [CMD_WIDTH-1:0]     w_head;
    logic                     w_full;
    logic                     w_empty;
    logic [FIFO_AW:0]         w_count;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_head_we;
    logic [ADDRESS_WIDTH-1:0] w_head_address;
    logic [DATA_WIDTH-1:0]    w_head_data;
    logic                     w_empty_next;
    state_e                   w_state_next;
    state_e                   r_state;
    logic                     r_rd_valid;
    logic [DATA_WIDTH-1:0]    r_rd_data;

    assign w_push = cmd_valid_input && !w_full;
    assign w_pop  = !w_empty && is_RAM_available_input;

    ram_port2_requester_cmd_fifo #(
        .WIDTH   (CMD_WIDTH),
        .FIFO_AW (FIFO_AW)
    ) u_cmd_fifo (
        .i_clk   (clk_input),
        .i_rst_n (rst_n_input),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({cmd_we_input, cmd_address_input, cmd_data_input}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_we      = w_head[CMD_WIDTH-1];
    assign w_head_address = w_head[DATA_WIDTH +: ADDRESS_WIDTH];
    assign w_head_data    = w_head[DATA_WIDTH-1:0];

    // Port 2 follows the FIFO head directly so an access is never lost when CE1 rises
    assign CE2_output      = !w_empty;
    assign WE2_output      = w_head_we && !w_empty;
    assign address2_output = w_empty ? ADDRESS_WIDTH'(0) : w_head_address;
    assign data2_inout     = (CE2_output && WE2_output) ? w_head_data : {DATA_WIDTH{1'bz}};

    assign cmd_ready_output = !w_full;
    assign busy_output      = (r_state != ST_IDLE);
    assign rd_valid_output  = r_rd_valid;
    assign rd_data_output   = r_rd_data;

    // FIFO emptiness after this edge's push/pop
    always_comb begin
        w_empty_next = 1'b0;
        if (w_empty) begin
            w_empty_next = !w_push;
        end else begin
            w_empty_next = (w_count == (FIFO_AW+1)'(1)) && w_pop && !w_push;
        end
    end

    // Next FSM state from post-update occupancy and current availability
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_empty_next) begin
            w_state_next = ST_IDLE;
        end else if (is_RAM_available_input) begin
            w_state_next = ST_ISSUE;
        end else begin
            w_state_next = ST_STALL;
        end
    end

    // FSM state and read-return capture
    always_ff @(posedge clk_input or negedge rst_n_input) begin
        if (!rst_n_input) begin
            r_state    <= ST_IDLE;
            r_rd_valid <= 1'b0;
            r_rd_data  <= DATA_WIDTH'(0);
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= w_pop && !w_head_we;
            if (w_pop && !w_head_we) r_rd_data <= data2_inout;
        end
    end

`ifdef RAM_PORT2_STATS_EN
    logic                   w_stall;
    logic [STALL_CNT_W-1:0] r_stall_count;

    assign w_stall            = !w_empty && !is_RAM_available_input;
    assign stall_count_output = r_stall_count;

    // Saturating count of cycles where the head is held back by port 1
    always_ff @(posedge clk_input or negedge rst_n_input) begin
        if (!rst_n_input) begin
            r_stall_count <= STALL_CNT_W'(0);
        end else if (w_stall && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ram_port2_requester.sv
// Randomised self-checking bench for ram_port2_requester with a queue-based reference model.
module tb_ram_port2_requester;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          avail = 1'b0;
    logic          cmd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          we2;
    logic          ce2;
    logic [AW-1:0] addr2;
    tri   [DW-1:0] data2;
`ifdef RAM_PORT2_STATS_EN
    logic [15:0]   stall_count;
`endif

    int errors = 0;
    int checks = 0;

    // RAM seen through the arbiter: answers reads on port 2
    logic [DW-1:0] ram [16];
    assign data2 = (ce2 && !we2) ? ram[addr2[3:0]] : 8'hzz;

    always #5 clk = ~clk;

    ram_port2_requester #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_AW(2)) dut (
        .clk_input              (clk),
        .rst_n_input            (rst_n),
        .cmd_valid_input        (cmd_valid),
        .cmd_ready_output       (cmd_ready),
        .cmd_we_input           (cmd_we),
        .cmd_address_input      (cmd_addr),
        .cmd_data_input         (cmd_data),
        .rd_valid_output        (rd_valid),
        .rd_data_output         (rd_data),
        .busy_output            (busy),
        .is_RAM_available_input (avail),
        .WE2_output             (we2),
        .CE2_output             (ce2),
        .address2_output        (addr2),
        .data2_inout            (data2)
`ifdef RAM_PORT2_STATS_EN
        ,
        .stall_count_output     (stall_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending commands, a read returns one cycle after its pop
    cmd_t q[$];
    cmd_t m_h;
    int   m_sz;
    bit   m_pop;
    bit   m_push;
    bit   m_rv;
    logic [DW-1:0] m_rd;
    int   m_stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_rv    = 1'b0;
            m_rd    = '0;
            m_stall = 0;
            for (int i = 0; i < 16; i++) ram[i] = 8'(i * 37 + 5);
        end else begin
            m_sz   = q.size();
            m_pop  = (m_sz > 0) && avail;
            m_push = cmd_valid && (m_sz < DEPTH);
            m_rv   = 1'b0;
            if (m_sz > 0 && !avail && m_stall < 65535) m_stall++;
            if (m_pop) begin
                m_h = q.pop_front();
                if (m_h.we) ram[m_h.a[3:0]] = m_h.d;
                else begin
                    m_rv = 1'b1;
                    m_rd = ram[m_h.a[3:0]];
                end
            end
            if (m_push) q.push_back({cmd_we, cmd_addr, cmd_data});
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("ce2", 32'(ce2), 32'(q.size() != 0));
        chk("we2", 32'(we2), 32'((q.size() != 0) && q[0].we));
        chk("address2", 32'(addr2), (q.size() != 0) ? 32'(q[0].a) : 32'd0);
        if (q.size() != 0)
            chk("data2", 32'(data2), q[0].we ? 32'(q[0].d) : 32'(ram[q[0].a[3:0]]));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
`ifdef RAM_PORT2_STATS_EN
        chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    end

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic av);
        @(posedge clk);
        #1;
        cmd_valid = v;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_data  = d;
        avail     = av;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, then read it back
        drive(1'b1, 1'b1, 16'h0010, 8'h5A, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("wr_ce2", 32'(ce2), 32'd1);
        chk("wr_we2", 32'(we2), 32'd1);
        chk("wr_addr2", 32'(addr2), 32'h0010);
        chk("wr_data2", 32'(data2), 32'h5A);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("wr_ce2_drop", 32'(ce2), 32'd0);
        chk("wr_busy_drop", 32'(busy), 32'd0);
        drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("rd_we2", 32'(we2), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("rd_pulse", 32'(rd_valid), 32'd1);
        chk("rd_value", 32'(rd_data), 32'h5A);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("rd_pulse_end", 32'(rd_valid), 32'd0);

        // Three writes held off for five stall cycles
        drive(1'b1, 1'b1, 16'h0100, 8'h11, 1'b0);
        drive(1'b1, 1'b1, 16'h0101, 8'h22, 1'b0);
        drive(1'b1, 1'b1, 16'h0102, 8'h33, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("stall_addr2", 32'(addr2), 32'h0100);
        chk("stall_data2", 32'(data2), 32'h11);
`ifdef RAM_PORT2_STATS_EN
        chk("stall_five", 32'(stall_count), 32'd5);
`endif
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("order_2nd", 32'(addr2), 32'h0101);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("order_3rd", 32'(addr2), 32'h0102);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("order_empty", 32'(busy), 32'd0);

        // Fill to depth; the fifth offer is refused
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 16'(16'h0200 + i), 8'(8'h40 + i), 1'b0);
        drive(1'b1, 1'b1, 16'h0204, 8'h44, 1'b0);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("full_refused", 32'(cmd_ready), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("full_ready_back", 32'(cmd_ready), 32'd1);
        chk("full_next_head", 32'(addr2), 32'h0201);
        repeat (4) drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("full_drained", 32'(busy), 32'd0);

        // Full-rate push and pop of 16 mixed commands
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'($urandom), 16'($urandom_range(0, 15)), 8'($urandom), 1'b1);
        repeat (2) drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

        // Random traffic with random availability
        for (int i = 0; i < 400; i++)
            drive(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0));
        repeat (6) drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);

        // Reset with two commands queued
        drive(1'b1, 1'b1, 16'h0300, 8'h77, 1'b0);
        drive(1'b1, 1'b0, 16'h0301, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ce2", 32'(ce2), 32'd0);
        chk("rst_we2", 32'(we2), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        chk("rst_no_rd", 32'(rd_valid), 32'd0);
        chk("rst_empty", 32'(busy), 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
